// File: rtl/syn_clk_gen_if.sv
// Correction-request and synchronized-time bundle shared between the time
// generator (slave) and whatever drives corrections into it (master).
interface syn_clk_gen_if;
    logic        tsn_or_tte;
    logic [31:0] syn_clk_cycle;
    logic        corr_wr;
    logic [63:0] corr_offset;
    logic        corr_ack;
    logic        corr_drop;
    logic        corr_busy;
    logic        cycle_start;
    logic [63:0] syn_clk;

    modport master (
        output tsn_or_tte, syn_clk_cycle, corr_wr, corr_offset,
        input  corr_ack, corr_drop, corr_busy, cycle_start, syn_clk
    );

    modport slave (
        input  tsn_or_tte, syn_clk_cycle, corr_wr, corr_offset,
        output corr_ack, corr_drop, corr_busy, cycle_start, syn_clk
    );
endinterface

// File: rtl/syn_clk_gen.sv
// Local synchronized time generator: free-running 1588 time or 6802 cyclic
// time, with offset corrections applied either as one step or a 1 ns/cycle slew.
module syn_clk_gen #(
    parameter int unsigned STEP_NS     = 8,
    parameter int unsigned STEP_THRESH = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tsn_or_tte,
    input  logic [31:0] iv_syn_clk_cycle,
    input  logic        i_corr_wr,
    input  logic [63:0] iv_corr_offset,
    output logic        o_corr_ack,
    output logic        o_corr_drop,
    output logic        o_corr_busy,
    output logic        o_cycle_start,
    output logic [63:0] ov_syn_clk
);

    localparam int unsigned TW = 66;
    localparam logic signed [TW-1:0] STEP_S = $signed(TW'(STEP_NS));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        SLEW = 2'd2
    } state_t;

    state_t              r_state;
    logic signed [63:0]  r_offset;
    logic                r_mode;

    logic signed [TW-1:0] w_add;
    logic signed [TW-1:0] w_sum;
    logic signed [TW-1:0] w_cyc;
    logic [63:0]          w_next;
    logic                 w_wrap;
    logic [63:0]          w_abs;
    logic                 w_big;
    logic                 w_hold;
    logic                 w_last_slew;
    state_t               w_state_nxt;
    logic signed [63:0]   w_offset_nxt;
    logic                 w_ack;
    logic                 w_drop;

    // Time update: correction is folded into the increment, then the wrap rule runs.
    always_comb begin
        w_add  = STEP_S;
        w_next = '0;
        w_wrap = 1'b0;
        case (r_state)
            STEP:    w_add = STEP_S + TW'(r_offset);
            SLEW:    w_add = r_offset[63] ? (STEP_S - TW'(1)) : (STEP_S + TW'(1));
            default: w_add = STEP_S;
        endcase
        w_sum  = $signed({2'b00, ov_syn_clk}) + w_add;
        w_cyc  = $signed({34'd0, iv_syn_clk_cycle});
        w_hold = !r_mode && (iv_syn_clk_cycle == 32'd0);
        if (r_mode) begin
            w_next = 64'(w_sum);
        end else if (w_hold) begin
            w_next = '0;
        end else if (ov_syn_clk >= 64'(iv_syn_clk_cycle)) begin
            // cycle shrank below the running time: restart the cycle
            w_next = '0;
            w_wrap = 1'b1;
        end else if (w_sum >= w_cyc) begin
            w_next = 64'(w_sum - w_cyc);
            w_wrap = 1'b1;
        end else if (w_sum[TW-1]) begin
            w_next = 64'(w_sum + w_cyc);
        end else begin
            w_next = 64'(w_sum);
        end
    end

    // Request acceptance and correction sequencing.
    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_ack        = 1'b0;
        w_drop       = 1'b0;
        w_abs        = iv_corr_offset[63] ? (~iv_corr_offset + 64'd1) : iv_corr_offset;
        w_big        = (w_abs >= 64'(STEP_THRESH));
        w_last_slew  = (r_offset == 64'sd1) || (r_offset == -64'sd1);
        case (r_state)
            IDLE: begin
                if (i_corr_wr) begin
                    w_ack = 1'b1;
                    if (!w_hold && (iv_corr_offset != 64'd0)) begin
                        w_offset_nxt = $signed(iv_corr_offset);
                        w_state_nxt  = w_big ? STEP : SLEW;
                    end
                end
            end
            STEP: begin
                w_drop       = i_corr_wr;
                w_state_nxt  = IDLE;
                w_offset_nxt = '0;
            end
            SLEW: begin
                w_drop       = i_corr_wr;
                w_offset_nxt = r_offset[63] ? (r_offset + 64'sd1) : (r_offset - 64'sd1);
                if (w_last_slew || w_hold) begin
                    w_state_nxt  = IDLE;
                    w_offset_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_offset_nxt = '0;
            end
        endcase
    end

    // Mode change restarts time and abandons any correction in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_offset      <= '0;
            r_mode        <= i_tsn_or_tte;
            ov_syn_clk    <= '0;
            o_corr_ack    <= 1'b0;
            o_corr_drop   <= 1'b0;
            o_corr_busy   <= 1'b0;
            o_cycle_start <= 1'b0;
        end else if (i_tsn_or_tte != r_mode) begin
            r_state       <= IDLE;
            r_offset      <= '0;
            r_mode        <= i_tsn_or_tte;
            ov_syn_clk    <= '0;
            o_corr_ack    <= 1'b0;
            o_corr_drop   <= 1'b0;
            o_corr_busy   <= 1'b0;
            o_cycle_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_offset      <= w_offset_nxt;
            ov_syn_clk    <= w_next;
            o_corr_ack    <= w_ack;
            o_corr_drop   <= w_drop;
            o_corr_busy   <= (w_state_nxt != IDLE);
            o_cycle_start <= w_wrap;
        end
    end

endmodule

// File: tb/tb_syn_clk_gen.sv
// Directed bench for syn_clk_gen: cyclic/free-running time, step and slew
// corrections, busy drops, mode toggles, zero/shrinking cycle and reset.
module tb_syn_clk_gen;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    syn_clk_gen_if bus ();

    syn_clk_gen #(.STEP_NS(8), .STEP_THRESH(1000)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_tsn_or_tte     (bus.tsn_or_tte),
        .iv_syn_clk_cycle (bus.syn_clk_cycle),
        .i_corr_wr        (bus.corr_wr),
        .iv_corr_offset   (bus.corr_offset),
        .o_corr_ack       (bus.corr_ack),
        .o_corr_drop      (bus.corr_drop),
        .o_corr_busy      (bus.corr_busy),
        .o_cycle_start    (bus.cycle_start),
        .ov_syn_clk       (bus.syn_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic tsn, input logic [31:0] cyc);
        rst_n              = 1'b0;
        bus.corr_wr        = 1'b0;
        bus.corr_offset    = '0;
        bus.tsn_or_tte     = tsn;
        bus.syn_clk_cycle  = cyc;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.tsn_or_tte    = 1'b0;
        bus.syn_clk_cycle = 32'd80;
        bus.corr_wr       = 1'b0;
        bus.corr_offset   = '0;
        rst_n = 1'b0;
        #3;
        n_checks += 4;
        if (bus.syn_clk !== 64'd0) begin n_fail++; $display("FAIL reset_syn_clk got %0d want 0", bus.syn_clk); end
        if (bus.corr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", bus.corr_ack); end
        if (bus.corr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.corr_busy); end
        if (bus.cycle_start !== 1'b0) begin n_fail++; $display("FAIL reset_cycle_start got %b want 0", bus.cycle_start); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_checks += 1;
        if (bus.syn_clk !== 64'd8) begin n_fail++; $display("FAIL reset_first_edge got %0d want 8", bus.syn_clk); end
    endtask

    task automatic test_cyclic_6802();
        logic [63:0] exp;
        do_reset(1'b0, 32'd80);
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp = 64'((i * 8) % 80);
            n_checks += 2;
            if (bus.syn_clk !== exp) begin n_fail++; $display("FAIL cyclic_value edge %0d got %0d want %0d", i, bus.syn_clk, exp); end
            if (bus.cycle_start !== (exp == 64'd0)) begin n_fail++; $display("FAIL cyclic_pulse edge %0d got %b want %b", i, bus.cycle_start, exp == 64'd0); end
        end
    endtask

    task automatic test_step_1588();
        do_reset(1'b1, 32'd0);
        repeat (125) tick();
        n_checks += 1;
        if (bus.syn_clk !== 64'd1000) begin n_fail++; $display("FAIL step_setup got %0d want 1000", bus.syn_clk); end
        bus.corr_wr = 1'b1;
        bus.corr_offset = 64'd5000;
        tick();
        bus.corr_wr = 1'b0;
        n_checks += 3;
        if (bus.syn_clk !== 64'd1008) begin n_fail++; $display("FAIL step_edge_n got %0d want 1008", bus.syn_clk); end
        if (bus.corr_ack !== 1'b1) begin n_fail++; $display("FAIL step_ack got %b want 1", bus.corr_ack); end
        if (bus.corr_busy !== 1'b1) begin n_fail++; $display("FAIL step_busy got %b want 1", bus.corr_busy); end
        tick();
        n_checks += 3;
        if (bus.syn_clk !== 64'd6016) begin n_fail++; $display("FAIL step_applied got %0d want 6016", bus.syn_clk); end
        if (bus.corr_busy !== 1'b0) begin n_fail++; $display("FAIL step_busy_clear got %b want 0", bus.corr_busy); end
        if (bus.corr_ack !== 1'b0) begin n_fail++; $display("FAIL step_ack_clear got %b want 0", bus.corr_ack); end
        tick();
        n_checks += 1;
        if (bus.syn_clk !== 64'd6024) begin n_fail++; $display("FAIL step_after got %0d want 6024", bus.syn_clk); end
    endtask

    task automatic test_slew_1588();
        logic [63:0] exp_v [4] = '{64'd6039, 64'd6046, 64'd6053, 64'd6061};
        logic        exp_b [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bus.corr_wr = 1'b1;
        bus.corr_offset = -64'sd3;
        tick();
        bus.corr_wr = 1'b0;
        n_checks += 3;
        if (bus.syn_clk !== 64'd6032) begin n_fail++; $display("FAIL slew_edge_n got %0d want 6032", bus.syn_clk); end
        if (bus.corr_ack !== 1'b1) begin n_fail++; $display("FAIL slew_ack got %b want 1", bus.corr_ack); end
        if (bus.corr_busy !== 1'b1) begin n_fail++; $display("FAIL slew_busy0 got %b want 1", bus.corr_busy); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks += 2;
            if (bus.syn_clk !== exp_v[i]) begin n_fail++; $display("FAIL slew_value %0d got %0d want %0d", i, bus.syn_clk, exp_v[i]); end
            if (bus.corr_busy !== exp_b[i]) begin n_fail++; $display("FAIL slew_busy %0d got %b want %b", i, bus.corr_busy, exp_b[i]); end
        end
    endtask

    task automatic test_neg_step_6802();
        do_reset(1'b0, 32'd1000);
        repeat (124) tick();
        n_checks += 1;
        if (bus.syn_clk !== 64'd992) begin n_fail++; $display("FAIL negstep_setup got %0d want 992", bus.syn_clk); end
        bus.corr_wr = 1'b1;
        bus.corr_offset = -64'sd1000;
        tick();
        bus.corr_wr = 1'b0;
        n_checks += 3;
        if (bus.syn_clk !== 64'd0) begin n_fail++; $display("FAIL negstep_wrap got %0d want 0", bus.syn_clk); end
        if (bus.cycle_start !== 1'b1) begin n_fail++; $display("FAIL negstep_wrap_pulse got %b want 1", bus.cycle_start); end
        if (bus.corr_busy !== 1'b1) begin n_fail++; $display("FAIL negstep_busy got %b want 1", bus.corr_busy); end
        tick();
        n_checks += 3;
        if (bus.syn_clk !== 64'd8) begin n_fail++; $display("FAIL negstep_result got %0d want 8", bus.syn_clk); end
        if (bus.cycle_start !== 1'b0) begin n_fail++; $display("FAIL negstep_no_pulse got %b want 0", bus.cycle_start); end
        if (bus.corr_busy !== 1'b0) begin n_fail++; $display("FAIL negstep_idle got %b want 0", bus.corr_busy); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_v [4] = '{64'd34, 64'd43, 64'd52, 64'd61};
        logic        exp_b [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus.corr_wr = 1'b1;
        bus.corr_offset = 64'd5;
        tick();
        n_checks += 2;
        if (bus.syn_clk !== 64'd16) begin n_fail++; $display("FAIL b2b_first got %0d want 16", bus.syn_clk); end
        if (bus.corr_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ack got %b want 1", bus.corr_ack); end
        bus.corr_offset = 64'd100;
        tick();
        bus.corr_wr = 1'b0;
        n_checks += 3;
        if (bus.syn_clk !== 64'd25) begin n_fail++; $display("FAIL b2b_second got %0d want 25", bus.syn_clk); end
        if (bus.corr_drop !== 1'b1) begin n_fail++; $display("FAIL b2b_drop got %b want 1", bus.corr_drop); end
        if (bus.corr_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_no_ack got %b want 0", bus.corr_ack); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks += 2;
            if (bus.syn_clk !== exp_v[i]) begin n_fail++; $display("FAIL b2b_value %0d got %0d want %0d", i, bus.syn_clk, exp_v[i]); end
            if (bus.corr_busy !== exp_b[i]) begin n_fail++; $display("FAIL b2b_busy %0d got %b want %b", i, bus.corr_busy, exp_b[i]); end
        end
        n_checks += 1;
        if (bus.corr_drop !== 1'b0) begin n_fail++; $display("FAIL b2b_drop_clear got %b want 0", bus.corr_drop); end
        bus.corr_wr = 1'b1;
        bus.corr_offset = 64'd2;
        tick();
        bus.corr_wr = 1'b0;
        n_checks += 2;
        if (bus.corr_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_later_ack got %b want 1", bus.corr_ack); end
        if (bus.syn_clk !== 64'd69) begin n_fail++; $display("FAIL b2b_later_value got %0d want 69", bus.syn_clk); end
        tick();
        tick();
        n_checks += 2;
        if (bus.syn_clk !== 64'd87) begin n_fail++; $display("FAIL b2b_later_slew got %0d want 87", bus.syn_clk); end
        if (bus.corr_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_later_idle got %b want 0", bus.corr_busy); end
    endtask

    task automatic test_mode_toggle();
        bus.corr_wr = 1'b1;
        bus.corr_offset = 64'd3;
        tick();
        bus.corr_wr = 1'b0;
        n_checks += 1;
        if (bus.syn_clk !== 64'd95) begin n_fail++; $display("FAIL toggle_setup got %0d want 95", bus.syn_clk); end
        bus.tsn_or_tte = 1'b1;
        tick();
        n_checks += 2;
        if (bus.syn_clk !== 64'd0) begin n_fail++; $display("FAIL toggle_zero got %0d want 0", bus.syn_clk); end
        if (bus.corr_busy !== 1'b0) begin n_fail++; $display("FAIL toggle_busy got %b want 0", bus.corr_busy); end
        tick();
        n_checks += 1;
        if (bus.syn_clk !== 64'd8) begin n_fail++; $display("FAIL toggle_aborted got %0d want 8", bus.syn_clk); end
    endtask

    task automatic test_reset_mid_step();
        bus.corr_wr = 1'b1;
        bus.corr_offset = 64'd5000;
        tick();
        bus.corr_wr = 1'b0;
        n_checks += 1;
        if (bus.corr_busy !== 1'b1) begin n_fail++; $display("FAIL rststep_busy got %b want 1", bus.corr_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (bus.syn_clk !== 64'd0) begin n_fail++; $display("FAIL rststep_clk got %0d want 0", bus.syn_clk); end
        if (bus.corr_busy !== 1'b0) begin n_fail++; $display("FAIL rststep_busy_clear got %b want 0", bus.corr_busy); end
        if (bus.corr_ack !== 1'b0) begin n_fail++; $display("FAIL rststep_ack got %b want 0", bus.corr_ack); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_checks += 1;
        if (bus.syn_clk !== 64'd8) begin n_fail++; $display("FAIL rststep_first got %0d want 8", bus.syn_clk); end
        tick();
        n_checks += 1;
        if (bus.syn_clk !== 64'd16) begin n_fail++; $display("FAIL rststep_discarded got %0d want 16", bus.syn_clk); end
    endtask

    task automatic test_cycle_zero_and_shrink();
        bus.tsn_or_tte = 1'b0;
        bus.syn_clk_cycle = 32'd0;
        tick();
        tick();
        n_checks += 2;
        if (bus.syn_clk !== 64'd0) begin n_fail++; $display("FAIL zero_hold got %0d want 0", bus.syn_clk); end
        if (bus.cycle_start !== 1'b0) begin n_fail++; $display("FAIL zero_pulse got %b want 0", bus.cycle_start); end
        bus.corr_wr = 1'b1;
        bus.corr_offset = 64'd5;
        tick();
        bus.corr_wr = 1'b0;
        n_checks += 3;
        if (bus.corr_ack !== 1'b1) begin n_fail++; $display("FAIL zero_ack got %b want 1", bus.corr_ack); end
        if (bus.corr_busy !== 1'b0) begin n_fail++; $display("FAIL zero_discard got %b want 0", bus.corr_busy); end
        if (bus.syn_clk !== 64'd0) begin n_fail++; $display("FAIL zero_hold2 got %0d want 0", bus.syn_clk); end
        bus.syn_clk_cycle = 32'd80;
        repeat (5) tick();
        n_checks += 1;
        if (bus.syn_clk !== 64'd40) begin n_fail++; $display("FAIL shrink_setup got %0d want 40", bus.syn_clk); end
        bus.syn_clk_cycle = 32'd32;
        tick();
        n_checks += 2;
        if (bus.syn_clk !== 64'd0) begin n_fail++; $display("FAIL shrink_zero got %0d want 0", bus.syn_clk); end
        if (bus.cycle_start !== 1'b1) begin n_fail++; $display("FAIL shrink_pulse got %b want 1", bus.cycle_start); end
        tick();
        n_checks += 2;
        if (bus.syn_clk !== 64'd8) begin n_fail++; $display("FAIL shrink_next got %0d want 8", bus.syn_clk); end
        if (bus.cycle_start !== 1'b0) begin n_fail++; $display("FAIL shrink_pulse_clear got %b want 0", bus.cycle_start); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.tsn_or_tte    = 1'b0;
        bus.syn_clk_cycle = 32'd80;
        bus.corr_wr       = 1'b0;
        bus.corr_offset   = '0;
        #12;
        test_reset();
        test_cyclic_6802();
        test_step_1588();
        test_slew_1588();
        test_neg_step_6802();
        test_back_to_back();
        test_mode_toggle();
        test_reset_mid_step();
        test_cycle_zero_and_shrink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
